// File: rtl/alu_sched.sv
// alu_sched: arbitrates two requesters onto one shared combinational ALU.
// An operation is granted from IDLE, held in EXEC for a fixed wait that
// depends on the function code, and its results are captured on the last
// EXEC edge. The one-cycle DONE state carries the completion pulse.
// MULT (5'h1E) and DIV (5'h1F) also update the HI/LO registers.

module alu_sched #(
    parameter int ALU_WAIT = 1,
    parameter int MD_WAIT  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] s0,
    input  logic [31:0] t0,
    input  logic [31:0] s1,
    input  logic [31:0] t1,
    input  logic [4:0]  fs0,
    input  logic [4:0]  fs1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [31:0] alu_s,
    output logic [31:0] alu_t,
    output logic [4:0]  alu_fs,
    input  logic [31:0] alu_yhi,
    input  logic [31:0] alu_ylo,
    input  logic        alu_n,
    input  logic        alu_z,
    input  logic        alu_c,
    input  logic        alu_v,
    output logic [31:0] y_hi,
    output logic [31:0] y_lo,
    output logic        n,
    output logic        z,
    output logic        c,
    output logic        v,
    output logic [31:0] hi_reg,
    output logic [31:0] lo_reg,
    output logic        done,
    output logic        done_id,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The counter holds "remaining EXEC cycles minus one", so it is loaded
    // with wait-1 and the capture happens when it reads zero.
    localparam logic [3:0] ALU_CNT = 4'(ALU_WAIT - 1);
    localparam logic [3:0] MD_CNT  = 4'(MD_WAIT - 1);
    localparam logic [4:0] FS_MULT = 5'h1E;
    localparam logic [4:0] FS_DIV  = 5'h1F;

    // Multi-cycle MULT/DIV codes use the long wait and write HI/LO.
    function automatic logic is_md(input logic [4:0] fs);
        return (fs == FS_MULT) || (fs == FS_DIV);
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  cnt_r;
    logic        lp_r;

    logic        req_any_s;
    logic        grant_id_s;
    logic [31:0] sel_s_s;
    logic [31:0] sel_t_s;
    logic [4:0]  sel_fs_s;

    logic        launch_s;
    logic        capture_s;
    logic        gnt0_nxt_s;
    logic        gnt1_nxt_s;
    logic        busy_nxt_s;
    logic        md_cur_s;

    // Arbitration: a lone request wins; on a tie the requester that was not
    // served last wins. The winner's operands are muxed for latching.
    always_comb begin
        req_any_s = req0 | req1;
        if (req0 && req1) begin
            grant_id_s = ~lp_r;
        end else if (req0) begin
            grant_id_s = 1'b0;
        end else begin
            grant_id_s = 1'b1;
        end
        if (grant_id_s) begin
            sel_s_s  = s1;
            sel_t_s  = t1;
            sel_fs_s = fs1;
        end else begin
            sel_s_s  = s0;
            sel_t_s  = t0;
            sel_fs_s = fs0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_any_s) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_EXEC;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output decode: strobes for launch/capture and next values of the
    // registered handshake outputs.
    always_comb begin
        launch_s   = 1'b0;
        capture_s  = 1'b0;
        gnt0_nxt_s = 1'b0;
        gnt1_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_any_s) begin
                    launch_s   = 1'b1;
                    gnt0_nxt_s = ~grant_id_s;
                    gnt1_nxt_s = grant_id_s;
                end else begin
                    launch_s   = 1'b0;
                end
            end
            ST_EXEC: begin
                if (cnt_r == 4'd0) begin
                    capture_s = 1'b1;
                end else begin
                    capture_s = 1'b0;
                end
            end
            ST_DONE: begin
                capture_s = 1'b0;
            end
            default: begin
                capture_s = 1'b0;
            end
        endcase
        busy_nxt_s = (state_nxt_s != ST_IDLE);
        md_cur_s   = is_md(alu_fs);
    end

    // Handshake outputs, wait counter and last-served pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
            busy    <= 1'b0;
            cnt_r   <= 4'd0;
            lp_r    <= 1'b1;
        end else begin
            gnt0 <= gnt0_nxt_s;
            gnt1 <= gnt1_nxt_s;
            done <= capture_s;
            busy <= busy_nxt_s;
            if (launch_s) begin
                lp_r  <= grant_id_s;
                cnt_r <= is_md(sel_fs_s) ? MD_CNT : ALU_CNT;
            end else if ((state_r == ST_EXEC) && (cnt_r != 4'd0)) begin
                cnt_r <= cnt_r - 4'd1;
            end
            if (capture_s) begin
                done_id <= lp_r;
            end
        end
    end

    // Operand registers feeding the shared ALU; they hold between operations.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_s  <= 32'd0;
            alu_t  <= 32'd0;
            alu_fs <= 5'd0;
        end else if (launch_s) begin
            alu_s  <= sel_s_s;
            alu_t  <= sel_t_s;
            alu_fs <= sel_fs_s;
        end
    end

    // Result capture on the last EXEC edge. The ALU leaves C/V undefined for
    // MULT/DIV, so they are forced low there; only MULT/DIV write HI/LO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y_hi   <= 32'd0;
            y_lo   <= 32'd0;
            n      <= 1'b0;
            z      <= 1'b0;
            c      <= 1'b0;
            v      <= 1'b0;
            hi_reg <= 32'd0;
            lo_reg <= 32'd0;
        end else if (capture_s) begin
            y_hi <= alu_yhi;
            y_lo <= alu_ylo;
            n    <= alu_n;
            z    <= alu_z;
            if (md_cur_s) begin
                c      <= 1'b0;
                v      <= 1'b0;
                hi_reg <= alu_yhi;
                lo_reg <= alu_ylo;
            end else begin
                c <= alu_c;
                v <= alu_v;
            end
        end
    end

endmodule

// File: tb/tb_alu_sched.sv
// Testbench for alu_sched: a small ALU model answers the shared ALU port,
// a table of single operations is run with a scoreboard, and hand-written
// sequences cover ties, mid-operation reset and a request queued during EXEC.

module tb_alu_sched;

    localparam int ALU_WAIT = 1;
    localparam int MD_WAIT  = 4;
    localparam logic [4:0] FS_ADD  = 5'h02;
    localparam logic [4:0] FS_SUB  = 5'h03;
    localparam logic [4:0] FS_UNK  = 5'h15;
    localparam logic [4:0] FS_MULT = 5'h1E;
    localparam logic [4:0] FS_DIV  = 5'h1F;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [31:0] s0, t0, s1, t1;
    logic [4:0]  fs0, fs1;
    logic        gnt0, gnt1;
    logic [31:0] alu_s, alu_t;
    logic [4:0]  alu_fs;
    logic [31:0] alu_yhi, alu_ylo;
    logic        alu_n, alu_z, alu_c, alu_v;
    logic [31:0] y_hi, y_lo, hi_reg, lo_reg;
    logic        n, z, c, v;
    logic        done, done_id, busy;

    alu_sched #(.ALU_WAIT(ALU_WAIT), .MD_WAIT(MD_WAIT)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .s0(s0), .t0(t0), .s1(s1), .t1(t1),
        .fs0(fs0), .fs1(fs1),
        .gnt0(gnt0), .gnt1(gnt1),
        .alu_s(alu_s), .alu_t(alu_t), .alu_fs(alu_fs),
        .alu_yhi(alu_yhi), .alu_ylo(alu_ylo),
        .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .y_hi(y_hi), .y_lo(y_lo), .n(n), .z(z), .c(c), .v(v),
        .hi_reg(hi_reg), .lo_reg(lo_reg),
        .done(done), .done_id(done_id), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic is_md(input logic [4:0] fs);
        return (fs == FS_MULT) || (fs == FS_DIV);
    endfunction

    // Shared ALU model. For MULT/DIV it drives C/V high so that the forced
    // zero in the scheduler is observable.
    logic [63:0] prod_m;
    logic [32:0] sum_m;
    logic [31:0] yhi_m, ylo_m;
    logic        c_m, v_m;
    always_comb begin
        prod_m = {32'd0, alu_s} * {32'd0, alu_t};
        sum_m  = {1'b0, alu_s} + {1'b0, alu_t};
        yhi_m  = 32'd0;
        ylo_m  = 32'd0;
        c_m    = 1'b0;
        v_m    = 1'b0;
        case (alu_fs)
            FS_ADD: begin
                ylo_m = sum_m[31:0];
                c_m   = sum_m[32];
                v_m   = (alu_s[31] == alu_t[31]) && (sum_m[31] != alu_s[31]);
            end
            FS_SUB: begin
                ylo_m = alu_s - alu_t;
                c_m   = (alu_s < alu_t);
                v_m   = (alu_s[31] != alu_t[31]) && (ylo_m[31] != alu_s[31]);
            end
            FS_MULT: begin
                yhi_m = prod_m[63:32];
                ylo_m = prod_m[31:0];
                c_m   = 1'b1;
                v_m   = 1'b1;
            end
            FS_DIV: begin
                if (alu_t != 32'd0) begin
                    ylo_m = alu_s / alu_t;
                    yhi_m = alu_s % alu_t;
                end else begin
                    ylo_m = 32'd0;
                    yhi_m = 32'd0;
                end
                c_m = 1'b1;
                v_m = 1'b1;
            end
            default: begin
                ylo_m = alu_s ^ alu_t;
            end
        endcase
        alu_yhi = yhi_m;
        alu_ylo = ylo_m;
        alu_c   = c_m;
        alu_v   = v_m;
        if (is_md(alu_fs)) begin
            alu_n = yhi_m[31];
            alu_z = ({yhi_m, ylo_m} == 64'd0);
        end else begin
            alu_n = ylo_m[31];
            alu_z = (ylo_m == 32'd0);
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event did not occur within bound", name);
    endtask

    typedef struct {
        logic        id;
        logic [31:0] yhi;
        logic [31:0] ylo;
        logic [3:0]  nzcv;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    // Push the expected result of an operation, tracking HI/LO.
    task automatic sb_push(input logic id, input logic [4:0] fs, input logic [31:0] eyhi,
                           input logic [31:0] eylo, input logic [3:0] enzcv);
        exp_t e;
        if (is_md(fs)) begin
            model_hi = eyhi;
            model_lo = eylo;
        end
        e.id = id; e.yhi = eyhi; e.ylo = eylo; e.nzcv = enzcv;
        e.hi = model_hi; e.lo = model_lo;
        sb.push_back(e);
    endtask

    // Compare the completing operation against the oldest expectation.
    task automatic sb_pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            fail_now({tag, " unexpected done"});
        end else begin
            e = sb.pop_front();
            check({tag, " done_id"}, 64'(done_id), 64'(e.id));
            check({tag, " y_hi"}, 64'(y_hi), 64'(e.yhi));
            check({tag, " y_lo"}, 64'(y_lo), 64'(e.ylo));
            check({tag, " nzcv"}, 64'({n, z, c, v}), 64'(e.nzcv));
            check({tag, " hi_reg"}, 64'(hi_reg), 64'(e.hi));
            check({tag, " lo_reg"}, 64'(lo_reg), 64'(e.lo));
        end
    endtask

    task automatic drive_req(input logic id, input logic [31:0] s, input logic [31:0] t,
                             input logic [4:0] fs);
        if (id) begin
            req1 = 1'b1; s1 = s; t1 = t; fs1 = fs;
        end else begin
            req0 = 1'b1; s0 = s; t0 = t; fs0 = fs;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        model_hi = 32'd0;
        model_lo = 32'd0;
    endtask

    // One operation from IDLE: grant in cycle 1, done in cycle W+1.
    task automatic run_op(input logic id, input logic [31:0] s, input logic [31:0] t,
                          input logic [4:0] fs, input logic [31:0] eyhi, input logic [31:0] eylo,
                          input logic [3:0] enzcv, input string tag);
        int  w;
        bit  got_gnt;
        bit  got_done;
        w = is_md(fs) ? MD_WAIT : ALU_WAIT;
        sb_push(id, fs, eyhi, eylo, enzcv);
        drive_req(id, s, t, fs);
        got_gnt  = 1'b0;
        got_done = 1'b0;
        for (int cyc = 1; cyc <= 40 && !got_done; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (gnt0 || gnt1) begin
                got_gnt = 1'b1;
                check({tag, " gnt cycle"}, 64'(cyc), 64'd1);
                check({tag, " gnt pair"}, 64'({gnt0, gnt1}), id ? 64'd1 : 64'd2);
                req0 = 1'b0;
                req1 = 1'b0;
            end
            if (done) begin
                got_done = 1'b1;
                check({tag, " done cycle"}, 64'(cyc), 64'(w + 1));
                sb_pop_check(tag);
            end
        end
        if (!got_gnt) fail_now({tag, " gnt"});
        if (!got_done) fail_now({tag, " done"});
        @(posedge clk);
        @(negedge clk);
        check({tag, " idle busy"}, 64'(busy), 64'd0);
    endtask

    typedef struct {
        logic        id;
        logic [31:0] s;
        logic [31:0] t;
        logic [4:0]  fs;
        logic [31:0] yhi;
        logic [31:0] ylo;
        logic [3:0]  nzcv;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int gnt_ids[4];
        int gnt_cyc[4];
        int ng;
        int nd;
        int done_cnt;
        int g1_cyc;
        int d_cyc[2];

        vecs[0] = '{1'b0, 32'd5,          32'd3,          FS_ADD,  32'd0, 32'd8,          4'b0000};
        vecs[1] = '{1'b1, 32'd7,          32'd6,          FS_MULT, 32'd0, 32'd42,         4'b0000};
        vecs[2] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          FS_ADD,  32'd0, 32'd0,          4'b0110};
        vecs[3] = '{1'b1, 32'h7FFF_FFFF,  32'd1,          FS_ADD,  32'd0, 32'h8000_0000,  4'b1001};
        vecs[4] = '{1'b0, 32'd100,        32'd7,          FS_DIV,  32'd2, 32'd14,         4'b0000};
        vecs[5] = '{1'b1, 32'h0001_0000,  32'h0001_0000,  FS_MULT, 32'd1, 32'd0,          4'b0000};
        vecs[6] = '{1'b0, 32'd3,          32'd5,          FS_SUB,  32'd0, 32'hFFFF_FFFE,  4'b1010};
        vecs[7] = '{1'b1, 32'hF0F0_0000,  32'h0F0F_0000,  FS_UNK,  32'd0, 32'hFFFF_0000,  4'b1000};
        vecs[8] = '{1'b0, 32'h8000_0000,  32'd1,          FS_SUB,  32'd0, 32'h7FFF_FFFF,  4'b0001};

        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        s0 = 32'd0; t0 = 32'd0; s1 = 32'd0; t1 = 32'd0;
        fs0 = 5'd0; fs1 = 5'd0;

        // Reset values while reset is held low.
        #12;
        check("reset ctrl", 64'({busy, gnt0, gnt1, done, done_id}), 64'd0);
        check("reset y", {y_hi, y_lo}, 64'd0);
        check("reset hilo", {hi_reg, lo_reg}, 64'd0);
        check("reset alu st", {alu_s, alu_t}, 64'd0);
        check("reset fs flags", 64'({alu_fs, n, z, c, v}), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Table of single operations.
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].id, vecs[i].s, vecs[i].t, vecs[i].fs,
                   vecs[i].yhi, vecs[i].ylo, vecs[i].nzcv, $sformatf("vec%0d", i));
        end

        // Reset pulsed during EXEC cycle 2 of a DIV: abandoned, no done.
        drive_req(1'b0, 32'd100, 32'd7, FS_DIV);
        @(posedge clk);
        @(negedge clk);
        check("mid gnt0", 64'(gnt0), 64'd1);
        req0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid busy", 64'(busy), 64'd0);
        check("mid done", 64'(done), 64'd0);
        check("mid hilo", {hi_reg, lo_reg}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        done_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("mid no done", 64'(done_cnt), 64'd0);
        check("mid hilo after", {hi_reg, lo_reg}, 64'd0);
        check("mid busy after", 64'(busy), 64'd0);

        // Tie right after reset: grants alternate 0,1,0,1 every W+2 cycles.
        do_reset();
        drive_req(1'b0, 32'd1, 32'd2, FS_ADD);
        drive_req(1'b1, 32'd10, 32'd20, FS_ADD);
        ng = 0;
        nd = 0;
        for (int cyc = 1; cyc <= 60 && nd < 4; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (gnt0 || gnt1) begin
                check("tie onehot", 64'(gnt0 & gnt1), 64'd0);
                if (ng < 4) begin
                    gnt_ids[ng] = gnt1 ? 1 : 0;
                    gnt_cyc[ng] = cyc;
                end
                ng++;
                if (ng >= 4) begin
                    req0 = 1'b0;
                    req1 = 1'b0;
                end
            end
            if (done) begin
                check($sformatf("tie done%0d id", nd), 64'(done_id), 64'(nd % 2));
                check($sformatf("tie done%0d y_lo", nd), 64'(y_lo), (nd % 2) ? 64'd30 : 64'd3);
                nd++;
            end
        end
        if (ng != 4) fail_now("tie grant count");
        if (nd != 4) fail_now("tie done count");
        for (int k = 0; k < 4 && k < ng; k++) begin
            check($sformatf("tie gnt%0d id", k), 64'(gnt_ids[k]), 64'(k % 2));
            if (k > 0) begin
                check($sformatf("tie gap%0d", k), 64'(gnt_cyc[k] - gnt_cyc[k-1]), 64'(ALU_WAIT + 2));
            end
        end
        repeat (2) @(negedge clk);

        // req1 raised during a MULT of requester 0 waits for the next IDLE.
        sb_push(1'b0, FS_MULT, 32'd0, 32'd12, 4'b0000);
        sb_push(1'b1, FS_ADD, 32'd0, 32'd20, 4'b0000);
        drive_req(1'b0, 32'd3, 32'd4, FS_MULT);
        g1_cyc = 0;
        nd = 0;
        d_cyc[0] = 0;
        d_cyc[1] = 0;
        for (int cyc = 1; cyc <= 40 && nd < 2; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (gnt0) req0 = 1'b0;
            if (cyc == 2) drive_req(1'b1, 32'd9, 32'd11, FS_ADD);
            if (gnt1) begin
                g1_cyc = cyc;
                req1 = 1'b0;
                check("queued alu_s/t", {alu_s, alu_t}, {32'd9, 32'd11});
                check("queued alu_fs", 64'(alu_fs), 64'(FS_ADD));
            end
            if (done) begin
                d_cyc[nd] = cyc;
                sb_pop_check($sformatf("queued op%0d", nd));
                nd++;
            end
        end
        if (nd != 2) fail_now("queued done count");
        check("queued done0 cycle", 64'(d_cyc[0]), 64'(MD_WAIT + 1));
        check("queued gnt1 cycle", 64'(g1_cyc), 64'(MD_WAIT + 3));
        check("queued done1 cycle", 64'(d_cyc[1]), 64'(MD_WAIT + 3 + ALU_WAIT));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
